// File: rtl/bus_io_ctrl_pkg.sv
// Shared definitions for the CPU bus-side I/O controller.
//   - I/O register addresses (full 32-bit byte addresses)
//   - STATUS register bit positions
//   - stall/timeout FSM state encoding
//   - value returned by a load that is completed by the timeout
package bus_io_pkg;

  localparam logic [31:0] ADDR_IN_DATA  = 32'h0000_0404;
  localparam logic [31:0] ADDR_OUT_DATA = 32'h0000_0408;
  localparam logic [31:0] ADDR_STATUS   = 32'h0000_040C;

  localparam int STAT_IN_FULL  = 0;
  localparam int STAT_OUT_FULL = 1;
  localparam int STAT_ERR      = 2;

  localparam logic [31:0] FORCED_RD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FORCE = 2'd2
  } stall_state_e;

endpackage

// File: rtl/bus_io_ctrl_io_buf1.sv
// io_buf1: one-entry holding register with valid/ready on both sides.
//   s_valid/s_ready/s_data : write side; a word is taken when s_valid & s_ready
//   m_valid/m_ready/m_data : read side; the word is released when m_valid & m_ready
// s_ready is ~full, so a full entry cannot be refilled in the cycle it drains;
// the next word can only be taken from the following cycle.
module io_buf1 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         full;
  logic [W-1:0] data;

  assign s_ready = ~full;
  assign m_valid = full;
  assign m_data  = data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      // NOTE: the data word is reset as well because it is visible on a port
      // (out_data must read 0 after reset), not only the full flag.
      data <= '0;
    end else if (s_valid && s_ready) begin
      full <= 1'b1;
      data <= s_data;
    end else if (m_valid && m_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_io_ctrl.sv
// bus_io_ctrl: bus-side controller between the single-cycle CPU and the data
// RAM plus one input and one output I/O port.
//   clk, rst          : clock, synchronous active-high reset
//   c_bus[1:0]        : CPU control, [1] store, [0] load (2'b11 acts as store)
//   a_bus, d_bus_2    : CPU byte address and store data
//   d_bus_1[33:0]     : to CPU {write-ready, read-ready, read data}
//   dmem_a/d/we/spo   : RAM word address, write data, write enable, read data
//   in_valid/ready/data   : input device handshake (into the input buffer)
//   out_valid/ready/data  : output device handshake (from the output buffer)
//   err               : sticky timeout flag, cleared by STATUS write bit 2
// Addresses above IO_BASE are I/O; everything else goes to RAM. Blocked I/O
// accesses are completed by force after TIMEOUT_CYC cycles (0 = never).
module bus_io_ctrl
  import bus_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE     = 32'h0000_0400,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  c_bus,
  input  logic [31:0] a_bus,
  input  logic [31:0] d_bus_2,
  output logic [33:0] d_bus_1,
  output logic [7:0]  dmem_a,
  output logic [31:0] dmem_d,
  output logic        dmem_we,
  input  logic [31:0] dmem_spo,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err
);

  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [15:0] TO_LAST = (TIMEOUT_CYC > 0) ? 16'(TIMEOUT_CYC - 1) : 16'd0;

  stall_state_e state, state_next;
  logic [15:0]  cnt, cnt_next;
  logic         err_set, err_clr;

  logic         is_io, sel_in, sel_out, sel_status;
  logic         is_load, is_store, forcing, blocked;
  logic         in_full, in_pop, out_full, out_space, out_push;
  logic [31:0]  in_word, status_word, rd_data;
  logic         rd_ready, wr_ready;

  // ---------------------------------------------------------------- decode
  assign is_io      = (a_bus > IO_BASE);
  assign sel_in     = is_io && (a_bus == ADDR_IN_DATA);
  assign sel_out    = is_io && (a_bus == ADDR_OUT_DATA);
  assign sel_status = is_io && (a_bus == ADDR_STATUS);
  assign is_store   = c_bus[1];
  assign is_load    = (c_bus == 2'b01);
  assign forcing    = (state == ST_FORCE);

  // A blocked access is one whose own ready bit is low; the forced cycle
  // never counts as blocked.
  assign blocked = !forcing &&
                   ((is_load && sel_in && !in_full) || (is_store && sel_out && !out_space));

  assign dmem_a  = a_bus[9:2];
  assign dmem_d  = d_bus_2;
  assign d_bus_1 = {wr_ready, rd_ready, rd_data};

  always_comb begin
    status_word                = '0;
    status_word[STAT_IN_FULL]  = in_full;
    status_word[STAT_OUT_FULL] = out_full;
    status_word[STAT_ERR]      = err;
  end

  // ------------------------------------------------- ready / read-data mux
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    rd_data  = '0;
    rd_ready = 1'b1;
    wr_ready = 1'b1;
    dmem_we  = 1'b0;
    in_pop   = 1'b0;
    out_push = 1'b0;
    err_clr  = 1'b0;
    if (!is_io) begin
      rd_data = dmem_spo;
      dmem_we = is_store;
    end else if (forcing) begin
      // Forced completion: both ready, loads see the marker value, stores
      // are dropped and neither buffer changes.
      rd_data = FORCED_RD;
    end else if (sel_in) begin
      rd_data  = in_word;
      rd_ready = in_full;
      in_pop   = is_load && in_full;
    end else if (sel_out) begin
      // Depends only on the buffer state, never on out_ready.
      wr_ready = out_space;
      out_push = is_store && out_space;
    end else if (sel_status) begin
      rd_data = status_word;
      err_clr = is_store && d_bus_2[STAT_ERR];
    end
  end

  // ---------------------------------------------------------- buffers
  io_buf1 #(.W(32)) u_in_buf (
    .clk     (clk),
    .rst     (rst),
    .s_valid (in_valid),
    .s_ready (in_ready),
    .s_data  (in_data),
    .m_valid (in_full),
    .m_ready (in_pop),
    .m_data  (in_word)
  );

  io_buf1 #(.W(32)) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .s_valid (out_push),
    .s_ready (out_space),
    .s_data  (d_bus_2),
    .m_valid (out_full),
    .m_ready (out_ready),
    .m_data  (out_data)
  );

  assign out_valid = out_full;

  // ---------------------------------------------------------- stall FSM
  // The counter holds the number of blocked cycles seen so far; the cycle in
  // which it reaches TO_LAST is the TIMEOUT_CYC-th blocked cycle, so the
  // forced cycle lands exactly TIMEOUT_CYC cycles after the first one.
  always_comb begin
    state_next = ST_IDLE;
    cnt_next   = '0;
    err_set    = 1'b0;
    unique case (state)
      ST_IDLE, ST_STALL: begin
        if (blocked) begin
          if (TO_EN && (cnt == TO_LAST)) begin
            state_next = ST_FORCE;
            err_set    = 1'b1;
          end else begin
            state_next = ST_STALL;
            cnt_next   = cnt + 16'd1;
          end
        end
      end
      ST_FORCE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // A timeout wins over a simultaneous STATUS clear.
      err   <= err_set | (err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_bus_io_ctrl.sv
// Directed self-checking bench for bus_io_ctrl (TIMEOUT_CYC = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 2 units after the edge, well away from it.
module tb_bus_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  c_bus;
  logic [31:0] a_bus, d_bus_2, dmem_spo, in_data, out_data, dmem_d;
  logic [33:0] d_bus_1;
  logic [7:0]  dmem_a;
  logic        dmem_we, in_valid, in_ready, out_valid, out_ready, err;

  int n_cmp = 0;
  int n_bad = 0;

  bus_io_ctrl #(.IO_BASE(32'h0000_0400), .TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .c_bus     (c_bus),
    .a_bus     (a_bus),
    .d_bus_2   (d_bus_2),
    .d_bus_1   (d_bus_1),
    .dmem_a    (dmem_a),
    .dmem_d    (dmem_d),
    .dmem_we   (dmem_we),
    .dmem_spo  (dmem_spo),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; c_bus = 2'b00; a_bus = '0; d_bus_2 = '0; dmem_spo = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    c_bus = 2'b01; a_bus = 32'h40C;
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (d_bus_1 !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL reset_status got %h want 3_00000000", d_bus_1); end
    step();
  endtask

  task automatic test_ram();
    c_bus = 2'b10; a_bus = 32'h10; d_bus_2 = 32'h1234_5678;
    settle();
    n_cmp++; if (dmem_we !== 1'b1) begin n_bad++; $display("FAIL ram_we got %b want 1", dmem_we); end
    n_cmp++; if (dmem_a !== 8'd4) begin n_bad++; $display("FAIL ram_addr got %0d want 4", dmem_a); end
    n_cmp++; if (dmem_d !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_wdata got %h want 12345678", dmem_d); end
    step();
    c_bus = 2'b01; dmem_spo = 32'h1234_5678;
    settle();
    n_cmp++; if (d_bus_1 !== {2'b11, 32'h1234_5678}) begin n_bad++; $display("FAIL ram_load got %h want 3_12345678", d_bus_1); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL ram_load_we got %b want 0", dmem_we); end
    step();
    c_bus = 2'b00; dmem_spo = '0;
  endtask

  task automatic test_input();
    c_bus = 2'b01; a_bus = 32'h404; in_valid = 1'b0;
    settle();
    n_cmp++; if (d_bus_1[32] !== 1'b0) begin n_bad++; $display("FAIL in_empty_rdy got %b want 0", d_bus_1[32]); end
    in_valid = 1'b1; in_data = 32'hCAFE;
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_empty got %b want 1", in_ready); end
    step();
    in_data = 32'hBEEF;  // offered while the buffer drains: must not be taken
    settle();
    n_cmp++; if (d_bus_1[32:0] !== {1'b1, 32'hCAFE}) begin n_bad++; $display("FAIL in_read got %h want 1_0000cafe", d_bus_1[32:0]); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_full got %b want 0", in_ready); end
    step();
    c_bus = 2'b00;
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_after_drain got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; c_bus = 2'b01;
    settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL in_refill_full got %b want 0", in_ready); end
    n_cmp++; if (d_bus_1[32:0] !== {1'b1, 32'hBEEF}) begin n_bad++; $display("FAIL in_read2 got %h want 1_0000beef", d_bus_1[32:0]); end
    step();
    c_bus = 2'b00;
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_end got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_back_to_back();
    c_bus = 2'b10; a_bus = 32'h408; d_bus_2 = 32'd5; out_ready = 1'b0;
    settle();
    n_cmp++; if (d_bus_1[33] !== 1'b1) begin n_bad++; $display("FAIL out_wr1_rdy got %b want 1", d_bus_1[33]); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL out_io_we got %b want 0", dmem_we); end
    step();
    d_bus_2 = 32'd6;
    settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL out_valid1 got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'd5) begin n_bad++; $display("FAIL out_data1 got %0d want 5", out_data); end
    n_cmp++; if (d_bus_1[33] !== 1'b0) begin n_bad++; $display("FAIL out_wr2_c1 got %b want 0", d_bus_1[33]); end
    step();
    settle();
    n_cmp++; if (d_bus_1[33] !== 1'b0) begin n_bad++; $display("FAIL out_wr2_c2 got %b want 0", d_bus_1[33]); end
    step();
    out_ready = 1'b1;
    settle();
    n_cmp++; if (d_bus_1[33] !== 1'b0) begin n_bad++; $display("FAIL out_wr2_drain got %b want 0", d_bus_1[33]); end
    step();
    out_ready = 1'b0;
    settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL out_valid_drained got %b want 0", out_valid); end
    n_cmp++; if (d_bus_1[33] !== 1'b1) begin n_bad++; $display("FAIL out_wr2_ok got %b want 1", d_bus_1[33]); end
    step();
    c_bus = 2'b00;
    settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL out_valid2 got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'd6) begin n_bad++; $display("FAIL out_data2 got %0d want 6", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL out_valid_end got %b want 0", out_valid); end
    step();
  endtask

  task automatic test_timeout();
    c_bus = 2'b01; a_bus = 32'h404; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (d_bus_1[32] !== 1'b0) begin n_bad++; $display("FAIL to_blocked_c%0d got %b want 0", i, d_bus_1[32]); end
      step();
    end
    settle();
    n_cmp++; if (d_bus_1 !== {2'b11, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL to_forced got %h want 3_ffffffff", d_bus_1); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err got %b want 1", err); end
    step();
    a_bus = 32'h40C;
    settle();
    n_cmp++; if (d_bus_1 !== {2'b11, 32'h4}) begin n_bad++; $display("FAIL to_status got %h want 3_00000004", d_bus_1); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL to_in_untouched got %b want 1", in_ready); end
    c_bus = 2'b10; d_bus_2 = 32'd4;
    step();
    c_bus = 2'b00;
    settle();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_clr got %b want 0", err); end
    step();
  endtask

  task automatic test_unmapped();
    c_bus = 2'b01; a_bus = 32'h500; dmem_spo = 32'hDEAD_BEEF;
    settle();
    n_cmp++; if (d_bus_1 !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL unmapped_load got %h want 3_00000000", d_bus_1); end
    step();
    c_bus = 2'b10; a_bus = 32'h400; d_bus_2 = 32'h55;
    settle();
    n_cmp++; if (dmem_we !== 1'b1) begin n_bad++; $display("FAIL wrap_we got %b want 1", dmem_we); end
    n_cmp++; if (dmem_a !== 8'd0) begin n_bad++; $display("FAIL wrap_addr got %0d want 0", dmem_a); end
    a_bus = 32'h500;
    settle();
    n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL unmapped_we got %b want 0", dmem_we); end
    step();
    c_bus = 2'b00; dmem_spo = '0;
  endtask

  task automatic test_reset_mid_stall();
    c_bus = 2'b10; a_bus = 32'h408; d_bus_2 = 32'd7; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    step();
    in_valid = 1'b0; d_bus_2 = 32'd8;
    for (int i = 0; i < 4; i++) step();
    settle();
    n_cmp++; if (d_bus_1[33] !== 1'b1) begin n_bad++; $display("FAIL rs_forced_wr got %b want 1", d_bus_1[33]); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rs_err_set got %b want 1", err); end
    step();
    settle();
    n_cmp++; if (out_data !== 32'd7) begin n_bad++; $display("FAIL rs_store_dropped got %0d want 7", out_data); end
    n_cmp++; if (d_bus_1[33] !== 1'b0) begin n_bad++; $display("FAIL rs_blocked_again got %b want 0", d_bus_1[33]); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rs_in_full got %b want 0", in_ready); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; c_bus = 2'b00;
    settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rs_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rs_in_ready got %b want 1", in_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rs_err got %b want 0", err); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rs_out_data got %h want 0", out_data); end
    step();
    // A fresh blocked load must take the full timeout, proving IDLE with count 0.
    c_bus = 2'b01; a_bus = 32'h404;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (d_bus_1[32] !== 1'b0) begin n_bad++; $display("FAIL rs_idle_c%0d got %b want 0", i, d_bus_1[32]); end
      step();
    end
    settle();
    n_cmp++; if (d_bus_1[32:0] !== {1'b1, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL rs_idle_force got %h want 1_ffffffff", d_bus_1[32:0]); end
    step();
    c_bus = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_input();
    test_back_to_back();
    test_timeout();
    test_unmapped();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired: bench did not complete");
    $fatal(1, "watchdog");
  end

endmodule
